hazard_int_ctrl: RTL and testbench

//  Producer side of the pipeline-register stall/flush interface: generates write-enables and clears for PC, IF/ID, ID/EX.

---
 rtl/hazard_int_ctrl_pkg.sv | 30 +++
 rtl/hazard_int_ctrl_if.sv | 55 +++++
 rtl/hazard_int_ctrl.sv | 142 ++++++++++++++
 tb/tb_hazard_int_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_int_ctrl_pkg.sv
// Shared types for the hazard/interrupt controller: FSM states, PC-override
// selectors and the interrupt priority encoder.
package hic_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LOCK_IN  = 2'd1,
    ST_ISR      = 2'd2,
    ST_LOCK_OUT = 2'd3
  } state_e;

  // Source of PCOverrideVal when PCOverrideEn is high.
  localparam logic [1:0] PCSEL_NONE   = 2'd0;
  localparam logic [1:0] PCSEL_VECTOR = 2'd1;
  localparam logic [1:0] PCSEL_EPC    = 2'd2;

  // IntId is 3 bits wide, so the encoder covers up to eight request lines.
  localparam int INT_MAX = 8;

  // Lowest set index wins: bit 0 has the highest priority.
  function automatic logic [2:0] prio_enc(input logic [INT_MAX-1:0] req);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = INT_MAX - 1; i >= 0; i--) begin
      if (req[i]) idx = i[2:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/hazard_int_ctrl_if.sv
// Pipeline-facing bundle of the hazard/interrupt controller. The master side
// is the controller itself; the slave side is the pipeline and CP0.
interface hazard_int_ctrl_if #(
  parameter int INT_NUM = 6
);
  // ID/EX observation and interrupt sources
  logic [4:0]         IDRs;
  logic [4:0]         IDRt;
  logic               IDUsesRs;
  logic               IDUsesRt;
  logic               IDValid;
  logic [31:0]        IDPC;
  logic [4:0]         EXRd;
  logic               EXIsLoad;
  logic               EXRFWr;
  logic               BranchEX;
  logic               EretEX;
  logic [INT_NUM-1:0] IntReq;
  logic [INT_NUM-1:0] IntMask;
  logic               IntEnable;
  logic [31:0]        EPCIn;

  // Stall/flush/redirect controls
  logic               PCWrite;
  logic               IFIDWrite;
  logic               IFIDClear;
  logic               IDEXWrite;
  logic               IDEXClear;
  logic               PCOverrideEn;
  logic [31:0]        PCOverrideVal;
  logic               EPCWrite;
  logic [31:0]        EPCValue;
  logic               IntAck;
  logic [2:0]         IntId;
  logic               InIsr;

  modport master (
    input  IDRs, IDRt, IDUsesRs, IDUsesRt, IDValid, IDPC,
    input  EXRd, EXIsLoad, EXRFWr, BranchEX, EretEX,
    input  IntReq, IntMask, IntEnable, EPCIn,
    output PCWrite, IFIDWrite, IFIDClear, IDEXWrite, IDEXClear,
    output PCOverrideEn, PCOverrideVal, EPCWrite, EPCValue,
    output IntAck, IntId, InIsr
  );

  modport slave (
    output IDRs, IDRt, IDUsesRs, IDUsesRt, IDValid, IDPC,
    output EXRd, EXIsLoad, EXRFWr, BranchEX, EretEX,
    output IntReq, IntMask, IntEnable, EPCIn,
    input  PCWrite, IFIDWrite, IFIDClear, IDEXWrite, IDEXClear,
    input  PCOverrideEn, PCOverrideVal, EPCWrite, EPCValue,
    input  IntAck, IntId, InIsr
  );

endinterface

// File: rtl/hazard_int_ctrl.sv
// Stall/flush producer for PC, IF/ID and ID/EX: load-use stall, branch flush,
// and interrupt entry/ERET sequencing with a post-transition lockout window.
module hazard_int_ctrl
  import hic_pkg::*;
#(
  parameter int          INT_NUM    = 6,
  parameter logic [31:0] INT_VECTOR = 32'h0000_4180,
  parameter int          LOCKOUT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  hazard_int_ctrl_if.master hic
);

  localparam int CNT_W = (LOCKOUT > 1) ? $clog2(LOCKOUT) : 1;
  localparam logic [CNT_W-1:0] LOCK_INIT = CNT_W'(LOCKOUT - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic               in_isr_q, in_isr_d;
  logic [31:0]        epc_q, epc_d;
  logic [2:0]         int_id_q, int_id_d;

  logic [INT_NUM-1:0] req_masked;
  logic [INT_MAX-1:0] req_ext;
  logic [2:0]         req_idx;
  logic               pend;
  logic               loaduse;
  logic               accept;
  logic [1:0]         pc_sel;

  assign req_masked = hic.IntReq & hic.IntMask;
  assign req_ext    = INT_MAX'(req_masked);
  assign req_idx    = prio_enc(req_ext);
  assign pend       = hic.IntEnable & ~in_isr_q & (|req_masked);

  assign loaduse = hic.EXIsLoad & hic.EXRFWr & (hic.EXRd != 5'd0) &
                   ((hic.IDUsesRs & (hic.IDRs == hic.EXRd)) |
                    (hic.IDUsesRt & (hic.IDRt == hic.EXRd)));

  // ERET and taken branches both defer an interrupt to a later cycle.
  assign accept = (state_q == ST_RUN) & pend & hic.IDValid &
                  ~hic.EretEX & ~hic.BranchEX;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      lock_cnt_q <= '0;
      in_isr_q   <= 1'b0;
      epc_q      <= '0;
      int_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      in_isr_q   <= in_isr_d;
      epc_q      <= epc_d;
      int_id_q   <= int_id_d;
    end
  end

  // NOTE: every variable gets a default before the branches so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    in_isr_d   = in_isr_q;
    epc_d      = epc_q;
    int_id_d   = int_id_q;
    if (hic.EretEX) begin
      state_d    = ST_LOCK_OUT;
      lock_cnt_d = LOCK_INIT;
      in_isr_d   = 1'b0;
    end else if (accept) begin
      state_d    = ST_LOCK_IN;
      lock_cnt_d = LOCK_INIT;
      in_isr_d   = 1'b1;
      epc_d      = hic.IDPC;
      int_id_d   = req_idx;
    end else begin
      unique case (state_q)
        ST_LOCK_IN: begin
          if (lock_cnt_q == '0) state_d = ST_ISR;
          else                  lock_cnt_d = lock_cnt_q - CNT_W'(1);
        end
        ST_LOCK_OUT: begin
          if (lock_cnt_q == '0) state_d = ST_RUN;
          else                  lock_cnt_d = lock_cnt_q - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Outputs are purely combinational so ID/EX can sample its clear at negedge.
  always_comb begin
    hic.PCWrite      = 1'b1;
    hic.IFIDWrite    = 1'b1;
    hic.IFIDClear    = 1'b0;
    hic.IDEXWrite    = 1'b1;
    hic.IDEXClear    = 1'b0;
    hic.PCOverrideEn = 1'b0;
    hic.EPCWrite     = 1'b0;
    hic.IntAck       = 1'b0;
    pc_sel           = PCSEL_NONE;
    if (hic.EretEX) begin
      hic.PCOverrideEn = 1'b1;
      pc_sel           = PCSEL_EPC;
      hic.IFIDClear    = 1'b1;
      hic.IDEXClear    = 1'b1;
    end else if (hic.BranchEX) begin
      hic.IFIDClear = 1'b1;
      hic.IDEXClear = 1'b1;
    end else if (accept) begin
      hic.IntAck       = 1'b1;
      hic.EPCWrite     = 1'b1;
      hic.PCOverrideEn = 1'b1;
      pc_sel           = PCSEL_VECTOR;
      hic.IFIDClear    = 1'b1;
      hic.IDEXClear    = 1'b1;
    end else if (loaduse) begin
      hic.PCWrite   = 1'b0;
      hic.IFIDWrite = 1'b0;
      hic.IDEXClear = 1'b1;
    end
  end

  always_comb begin
    unique case (pc_sel)
      PCSEL_VECTOR: hic.PCOverrideVal = INT_VECTOR;
      PCSEL_EPC:    hic.PCOverrideVal = hic.EPCIn;
      default:      hic.PCOverrideVal = 32'h0;
    endcase
  end

  // CP0 writes EPC on the accept edge, so the strobe cycle forwards IDPC.
  assign hic.EPCValue = accept ? hic.IDPC : epc_q;
  assign hic.IntId    = accept ? req_idx  : int_id_q;
  assign hic.InIsr    = in_isr_q;

endmodule

// File: tb/tb_hazard_int_ctrl.sv
// Directed bench for hazard_int_ctrl: a table of single-cycle hazard vectors
// followed by hand-written interrupt entry/ERET/lockout/reset sequences.
module tb_hazard_int_ctrl;

  localparam int          INT_NUM    = 6;
  localparam logic [31:0] INT_VECTOR = 32'h0000_4180;
  localparam int          LOCKOUT    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_int_ctrl_if #(.INT_NUM(INT_NUM)) bus ();

  hazard_int_ctrl #(
    .INT_NUM(INT_NUM), .INT_VECTOR(INT_VECTOR), .LOCKOUT(LOCKOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hic(bus)
  );

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] ex_rd;
    logic       uses_rs;
    logic       uses_rt;
    logic       is_load;
    logic       rfwr;
    logic       branch;
    logic       ie;
    logic [5:0] req;
    logic [5:0] mask;
    logic       e_pcw;
    logic       e_ifidw;
    logic       e_ifidc;
    logic       e_idexc;
    logic       e_ack;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic quiet();
    bus.IDRs = 5'd0; bus.IDRt = 5'd0; bus.IDUsesRs = 1'b0; bus.IDUsesRt = 1'b0;
    bus.IDValid = 1'b1; bus.IDPC = 32'h0000_1000;
    bus.EXRd = 5'd0; bus.EXIsLoad = 1'b0; bus.EXRFWr = 1'b0;
    bus.BranchEX = 1'b0; bus.EretEX = 1'b0;
    bus.IntReq = '0; bus.IntMask = '1; bus.IntEnable = 1'b1; bus.EPCIn = 32'h0;
  endtask

  // Advance to 1 time unit after the next rising edge, where inputs change.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before comparing (well before negedge).
  task automatic settle();
    #3;
  endtask

  task automatic set_loaduse();
    bus.IDRs = 5'd8; bus.IDRt = 5'd1; bus.IDUsesRs = 1'b1; bus.IDUsesRt = 1'b1;
    bus.EXRd = 5'd8; bus.EXIsLoad = 1'b1; bus.EXRFWr = 1'b1;
  endtask

  int k;
  logic got_ack;

  initial begin
    //             rs  rt  rd  urs urt ld  rf  br  ie  req      mask     pcw ifw ifc idc ack
    vecs[0]  = '{5'd1, 5'd2, 5'd0, 1, 1, 0, 0, 0, 1, 6'h00, 6'h3f, 1, 1, 0, 0, 0};
    vecs[1]  = '{5'd8, 5'd1, 5'd8, 1, 1, 1, 1, 0, 1, 6'h00, 6'h3f, 0, 0, 0, 1, 0};
    vecs[2]  = '{5'd1, 5'd8, 5'd8, 1, 1, 1, 1, 0, 1, 6'h00, 6'h3f, 0, 0, 0, 1, 0};
    vecs[3]  = '{5'd0, 5'd0, 5'd0, 1, 1, 1, 1, 0, 1, 6'h00, 6'h3f, 1, 1, 0, 0, 0};
    vecs[4]  = '{5'd3, 5'd8, 5'd8, 1, 0, 1, 1, 0, 1, 6'h00, 6'h3f, 1, 1, 0, 0, 0};
    vecs[5]  = '{5'd8, 5'd8, 5'd8, 0, 1, 1, 1, 0, 1, 6'h00, 6'h3f, 0, 0, 0, 1, 0};
    vecs[6]  = '{5'd8, 5'd1, 5'd8, 1, 1, 0, 1, 0, 1, 6'h00, 6'h3f, 1, 1, 0, 0, 0};
    vecs[7]  = '{5'd8, 5'd1, 5'd8, 1, 1, 1, 0, 0, 1, 6'h00, 6'h3f, 1, 1, 0, 0, 0};
    vecs[8]  = '{5'd8, 5'd1, 5'd8, 1, 1, 1, 1, 1, 1, 6'h00, 6'h3f, 1, 1, 1, 1, 0};
    vecs[9]  = '{5'd1, 5'd2, 5'd0, 1, 1, 0, 0, 1, 1, 6'h00, 6'h3f, 1, 1, 1, 1, 0};
    vecs[10] = '{5'd1, 5'd2, 5'd0, 1, 1, 0, 0, 0, 1, 6'h01, 6'h00, 1, 1, 0, 0, 0};
    vecs[11] = '{5'd1, 5'd2, 5'd0, 1, 1, 0, 0, 0, 0, 6'h01, 6'h3f, 1, 1, 0, 0, 0};
    vecs[12] = '{5'd8, 5'd8, 5'd9, 1, 1, 1, 1, 0, 1, 6'h00, 6'h3f, 1, 1, 0, 0, 0};

    quiet();
    rst = 1'b1;
    #2;
    check("rst PCWrite",      bus.PCWrite,      1);
    check("rst IFIDWrite",    bus.IFIDWrite,    1);
    check("rst IDEXWrite",    bus.IDEXWrite,    1);
    check("rst IFIDClear",    bus.IFIDClear,    0);
    check("rst IDEXClear",    bus.IDEXClear,    0);
    check("rst PCOverrideEn", bus.PCOverrideEn, 0);
    check("rst InIsr",        bus.InIsr,        0);
    check("rst EPCValue",     bus.EPCValue,     0);
    check("rst IntId",        bus.IntId,        0);
    next_cycle();
    rst = 1'b0;

    // Single-cycle hazard table, all in RUN with no acceptable interrupt.
    for (int i = 0; i < NV; i++) begin
      next_cycle();
      quiet();
      bus.IDRs = vecs[i].rs; bus.IDRt = vecs[i].rt; bus.EXRd = vecs[i].ex_rd;
      bus.IDUsesRs = vecs[i].uses_rs; bus.IDUsesRt = vecs[i].uses_rt;
      bus.EXIsLoad = vecs[i].is_load; bus.EXRFWr = vecs[i].rfwr;
      bus.BranchEX = vecs[i].branch; bus.IntEnable = vecs[i].ie;
      bus.IntReq = vecs[i].req; bus.IntMask = vecs[i].mask;
      settle();
      check($sformatf("v%0d PCWrite", i),   bus.PCWrite,   vecs[i].e_pcw);
      check($sformatf("v%0d IFIDWrite", i), bus.IFIDWrite, vecs[i].e_ifidw);
      check($sformatf("v%0d IFIDClear", i), bus.IFIDClear, vecs[i].e_ifidc);
      check($sformatf("v%0d IDEXClear", i), bus.IDEXClear, vecs[i].e_idexc);
      check($sformatf("v%0d IntAck", i),    bus.IntAck,    vecs[i].e_ack);
    end

    // ERET outside an ISR: redirect and flush, InIsr stays low.
    next_cycle();
    quiet();
    bus.EretEX = 1'b1; bus.EPCIn = 32'h1234_5678;
    settle();
    check("eret0 PCOverrideEn",  bus.PCOverrideEn,  1);
    check("eret0 PCOverrideVal", bus.PCOverrideVal, 32'h1234_5678);
    check("eret0 IFIDClear",     bus.IFIDClear,     1);
    check("eret0 IDEXClear",     bus.IDEXClear,     1);
    next_cycle();
    quiet();
    settle();
    check("eret0 InIsr", bus.InIsr, 0);
    for (int i = 0; i < LOCKOUT + 1; i++) next_cycle();

    // Branch beats load-use and defers a pending interrupt by one cycle.
    quiet();
    set_loaduse();
    bus.BranchEX = 1'b1; bus.IntReq = 6'b001100; bus.IDPC = 32'h0000_2000;
    settle();
    check("br PCWrite",      bus.PCWrite,      1);
    check("br IFIDClear",    bus.IFIDClear,    1);
    check("br IDEXClear",    bus.IDEXClear,    1);
    check("br IntAck",       bus.IntAck,       0);
    check("br PCOverrideEn", bus.PCOverrideEn, 0);

    next_cycle();
    bus.BranchEX = 1'b0; bus.IDPC = 32'h0000_3010;
    settle();
    check("acc IntAck",        bus.IntAck,        1);
    check("acc EPCWrite",      bus.EPCWrite,      1);
    check("acc PCOverrideEn",  bus.PCOverrideEn,  1);
    check("acc PCOverrideVal", bus.PCOverrideVal, INT_VECTOR);
    check("acc IFIDClear",     bus.IFIDClear,     1);
    check("acc IDEXClear",     bus.IDEXClear,     1);
    check("acc PCWrite",       bus.PCWrite,       1);
    check("acc IFIDWrite",     bus.IFIDWrite,     1);

    next_cycle();
    quiet();
    bus.IntReq = 6'b001101; bus.IDPC = 32'h0000_3014;
    settle();
    check("isr InIsr",    bus.InIsr,    1);
    check("isr IntId",    bus.IntId,    2);
    check("isr EPCValue", bus.EPCValue, 32'h0000_3010);
    check("isr EPCWrite", bus.EPCWrite, 0);
    check("isr IntAck",   bus.IntAck,   0);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      settle();
      check($sformatf("isr hold%0d IntAck", i), bus.IntAck, 0);
    end

    // ERET from the handler, then the held request returns after lockout.
    next_cycle();
    bus.IntReq = 6'b001100; bus.EretEX = 1'b1; bus.EPCIn = 32'h0000_3010;
    settle();
    check("eret PCOverrideEn",  bus.PCOverrideEn,  1);
    check("eret PCOverrideVal", bus.PCOverrideVal, 32'h0000_3010);
    check("eret IFIDClear",     bus.IFIDClear,     1);
    check("eret IDEXClear",     bus.IDEXClear,     1);
    check("eret IntAck",        bus.IntAck,        0);

    next_cycle();
    bus.EretEX = 1'b0; bus.IDPC = 32'h0000_3020;
    settle();
    check("post-eret InIsr", bus.InIsr, 0);
    k = 1;
    got_ack = bus.IntAck;
    while (!got_ack && k < 10) begin
      next_cycle();
      settle();
      k++;
      got_ack = bus.IntAck;
    end
    check("reaccept seen",  got_ack, 1);
    check("reaccept delay", k, LOCKOUT + 1);

    next_cycle();
    settle();
    check("reaccept IntId",    bus.IntId,    2);
    check("reaccept EPCValue", bus.EPCValue, 32'h0000_3020);
    check("reaccept InIsr",    bus.InIsr,    1);

    // Asynchronous reset in the middle of LOCK_IN.
    #1;
    rst = 1'b1;
    bus.IDValid = 1'b0;
    #1;
    check("arst InIsr",        bus.InIsr,        0);
    check("arst EPCValue",     bus.EPCValue,     0);
    check("arst IntId",        bus.IntId,        0);
    check("arst PCWrite",      bus.PCWrite,      1);
    check("arst IDEXClear",    bus.IDEXClear,    0);
    check("arst PCOverrideEn", bus.PCOverrideEn, 0);
    check("arst IntAck",       bus.IntAck,       0);
    next_cycle();
    rst = 1'b0;
    bus.IDValid = 1'b1;
    settle();
    check("post-rst IntAck", bus.IntAck, 1);
    check("post-rst IntId",  bus.IntId,  2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
